// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet decoder: assembles 3/4-byte packets, tracks a clamped
// absolute cursor position and reports hysteretic bin indices per axis.
module ps2_mouse_tracker #(
  parameter int WIDTH          = 2048,
  parameter int HEIGHT         = 2048,
  parameter int BIN            = 100,
  parameter int HYSTERESIS     = 3,
  parameter int BIN_W          = 5,
  parameter int WHEEL          = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             button_left,
  output logic             button_right,
  output logic             button_middle,
  output logic [11:0]      pos_x,
  output logic [11:0]      pos_y,
  output logic [BIN_W-1:0] bin_x,
  output logic [BIN_W-1:0] bin_y,
  output logic [3:0]       wheel,
  output logic             packet_valid,
  output logic [7:0]       err_count
);

  // state | meaning
  // IDLE  | waiting for a byte0 with bit3 set
  // B1    | byte0 held, waiting for X byte
  // B2    | X byte held, waiting for Y byte
  // B3    | Y byte held, waiting for wheel byte (WHEEL=1 only)
  typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] X_RST = 12'(WIDTH / 2);
  localparam logic [11:0] Y_RST = 12'(HEIGHT / 2);
  localparam logic [BIN_W-1:0] BX_RST = BIN_W'((WIDTH / 2) / BIN);
  localparam logic [BIN_W-1:0] BY_RST = BIN_W'((HEIGHT / 2) / BIN);
  localparam logic signed [13:0] X_MAX = 14'(WIDTH - 1);
  localparam logic signed [13:0] Y_MAX = 14'(HEIGHT - 1);

  state_t state;
  logic [7:0] byte0, byte1, byte2;
  logic [TMR_W-1:0] tmr;

  logic final_byte, sync_err, timeout;
  logic [7:0] y_byte;
  logic signed [13:0] dx, dy, nx, ny;
  logic [11:0] nx_c, ny_c;

  assign sync_err   = rx_valid && (state == IDLE) && !rx_data[3];
  assign timeout    = !rx_valid && (state != IDLE) && (tmr == '0);
  assign final_byte = rx_valid && (((state == B2) && (WHEEL == 0)) || (state == B3));

  always_comb begin
    y_byte = (state == B3) ? byte2 : rx_data;
    dx = byte0[6] ? 14'sd0 : {{6{byte0[4]}}, byte1};
    dy = byte0[7] ? 14'sd0 : {{6{byte0[5]}}, y_byte};
    nx = $signed({2'b00, pos_x}) + dx;
    ny = $signed({2'b00, pos_y}) - dy;
    if (nx < 14'sd0)      nx_c = 12'd0;
    else if (nx > X_MAX)  nx_c = X_MAX[11:0];
    else                  nx_c = nx[11:0];
    if (ny < 14'sd0)      ny_c = 12'd0;
    else if (ny > Y_MAX)  ny_c = Y_MAX[11:0];
    else                  ny_c = ny[11:0];
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      byte0         <= '0;
      byte1         <= '0;
      byte2         <= '0;
      tmr           <= TMR_LOAD;
      button_left   <= 1'b0;
      button_right  <= 1'b0;
      button_middle <= 1'b0;
      pos_x         <= X_RST;
      pos_y         <= Y_RST;
      wheel         <= 4'd0;
      packet_valid  <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      packet_valid <= 1'b0;
      // sync error and timeout are mutually exclusive, but share one increment
      if ((sync_err || timeout) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      if (rx_valid)
        tmr <= TMR_LOAD;
      else if ((state != IDLE) && (tmr != '0))
        tmr <= tmr - 1'b1;

      case (state)
        IDLE: if (rx_valid && rx_data[3]) begin
          byte0 <= rx_data;
          state <= B1;
        end
        B1: if (timeout) state <= IDLE;
            else if (rx_valid) begin
              byte1 <= rx_data;
              state <= B2;
            end
        B2: if (timeout) state <= IDLE;
            else if (rx_valid) begin
              byte2 <= rx_data;
              state <= (WHEEL != 0) ? B3 : IDLE;
            end
        B3: if (timeout) state <= IDLE;
            else if (rx_valid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (final_byte) begin
        pos_x         <= nx_c;
        pos_y         <= ny_c;
        button_left   <= byte0[0];
        button_right  <= byte0[1];
        button_middle <= byte0[2];
        wheel         <= (WHEEL != 0) ? rx_data[3:0] : 4'd0;
        packet_valid  <= 1'b1;
      end
    end
  end

  function automatic logic [BIN_W-1:0] bin_next(input logic [11:0] p, input logic [BIN_W-1:0] b);
    int lo, hi, pi;
    pi = int'(p);
    lo = int'(b) * BIN;
    hi = lo + BIN + HYSTERESIS;
    if ((pi >= hi) || (pi + HYSTERESIS < lo))
      return BIN_W'(pi / BIN);
    return b;
  endfunction

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bin_x <= BX_RST;
      bin_y <= BY_RST;
    end else begin
      bin_x <= bin_next(pos_x, bin_x);
      bin_y <= bin_next(pos_y, bin_y);
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: standard and wheel instances with a short timeout.
module tb_ps2_mouse_tracker;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rxd0 = '0, rxd1 = '0;
  logic rxv0 = 1'b0, rxv1 = 1'b0;

  logic l0, r0, m0, pv0, l1, r1, m1, pv1;
  logic [11:0] px0, py0, px1, py1;
  logic [4:0] bx0, by0, bx1, by1;
  logic [3:0] wh0, wh1;
  logic [7:0] err0, err1;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  ps2_mouse_tracker #(.WHEEL(0), .TIMEOUT_CYCLES(T)) dut0 (
    .CLOCK_50(clk), .reset_n(rst_n), .rx_data(rxd0), .rx_valid(rxv0),
    .button_left(l0), .button_right(r0), .button_middle(m0),
    .pos_x(px0), .pos_y(py0), .bin_x(bx0), .bin_y(by0),
    .wheel(wh0), .packet_valid(pv0), .err_count(err0));

  ps2_mouse_tracker #(.WHEEL(1), .TIMEOUT_CYCLES(T)) dut1 (
    .CLOCK_50(clk), .reset_n(rst_n), .rx_data(rxd1), .rx_valid(rxv1),
    .button_left(l1), .button_right(r1), .button_middle(m1),
    .pos_x(px1), .pos_y(py1), .bin_x(bx1), .bin_y(by1),
    .wheel(wh1), .packet_valid(pv1), .err_count(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic send(input int sel, input logic [7:0] b);
    @(negedge clk);
    if (sel == 0) begin rxd0 = b; rxv0 = 1'b1; end
    else          begin rxd1 = b; rxv1 = 1'b1; end
    @(negedge clk);
    rxv0 = 1'b0; rxv1 = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(0, a); send(0, b); send(0, c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("rst_pos_x", px0, 1024);
    chk("rst_pos_y", py0, 1024);
    chk("rst_bin_x", bx0, 10);
    chk("rst_bin_y", by0, 10);
    chk("rst_err", err0, 0);
    chk("rst_pv", pv0, 0);
    chk("rst_btn", {m0, r0, l0}, 0);
    chk("rst_wheel1", wh1, 0);

    // basic packet, left button, dx=+16
    send3(8'h09, 8'h10, 8'h00);
    chk("pkt1_pv", pv0, 1);
    chk("pkt1_x", px0, 1040);
    chk("pkt1_left", l0, 1);
    idle(1);
    chk("pkt1_pv_pulse", pv0, 0);
    chk("pkt1_binx", bx0, 10);

    // hysteresis walk 1100 -> 1103 -> 1099 -> 1096
    send3(8'h08, 8'h3C, 8'h00); idle(1);
    chk("hys_1100_x", px0, 1100);
    chk("hys_1100_bin", bx0, 10);
    chk("hys_left_clr", l0, 0);
    send3(8'h08, 8'h03, 8'h00); idle(1);
    chk("hys_1103_bin", bx0, 11);
    send3(8'h18, 8'hFC, 8'h00); idle(1);
    chk("hys_1099_x", px0, 1099);
    chk("hys_1099_bin", bx0, 11);
    send3(8'h18, 8'hFD, 8'h00); idle(1);
    chk("hys_1096_bin", bx0, 10);

    // lower X clamp, then X overflow, then upper Y clamp
    do_reset();
    send3(8'h18, 8'h00, 8'h00); chk("clamp_x1", px0, 768);
    send3(8'h18, 8'h00, 8'h00); chk("clamp_x2", px0, 512);
    send3(8'h18, 8'h00, 8'h00); chk("clamp_x3", px0, 256);
    send3(8'h18, 8'h00, 8'h00); chk("clamp_x4", px0, 0);
    send3(8'h18, 8'h00, 8'h00); chk("clamp_x5", px0, 0);
    send3(8'h48, 8'hFF, 8'h00);
    chk("ovf_pv", pv0, 1);
    chk("ovf_x", px0, 0);
    chk("ovf_y", py0, 1024);
    send3(8'h28, 8'h00, 8'h00); chk("clamp_y1", py0, 1280);
    send3(8'h28, 8'h00, 8'h00); chk("clamp_y2", py0, 1536);
    send3(8'h28, 8'h00, 8'h00); chk("clamp_y3", py0, 1792);
    send3(8'h28, 8'h00, 8'h00); chk("clamp_y4", py0, 2047);
    idle(1);
    chk("clamp_biny", by0, 20);

    // stray byte then a good packet
    do_reset();
    send(0, 8'h00);
    idle(1);
    chk("stray_err", err0, 1);
    chk("stray_pv", pv0, 0);
    send3(8'h08, 8'h05, 8'h03);
    chk("stray_x", px0, 1029);
    chk("stray_y", py0, 1021);
    chk("stray_err2", err0, 1);

    // reset mid-packet discards partial bytes
    do_reset();
    send(0, 8'h08); send(0, 8'h05);
    do_reset();
    send3(8'h08, 8'h01, 8'h00);
    chk("midrst_x", px0, 1025);
    chk("midrst_err", err0, 0);

    // inter-byte timeout
    do_reset();
    send(0, 8'h08); send(0, 8'h05);
    idle(T + 4);
    chk("tmo_err", err0, 1);
    chk("tmo_pv", pv0, 0);
    send3(8'h08, 8'h01, 8'h00);
    chk("tmo_x", px0, 1025);
    chk("tmo_err2", err0, 1);

    // gaps shorter than the timeout keep the packet alive
    send(0, 8'h08); idle(T - 4);
    send(0, 8'h02); idle(T - 4);
    send(0, 8'h00);
    chk("slow_pv", pv0, 1);
    chk("slow_x", px0, 1027);
    chk("slow_err", err0, 1);

    // back-to-back strobes, right+middle buttons
    @(negedge clk); rxd0 = 8'h0E; rxv0 = 1'b1;
    @(negedge clk); rxd0 = 8'h02;
    @(negedge clk); rxd0 = 8'h01;
    @(negedge clk); rxv0 = 1'b0;
    chk("b2b_pv", pv0, 1);
    chk("b2b_x", px0, 1029);
    chk("b2b_y", py0, 1023);
    chk("b2b_btn", {m0, r0, l0}, 3'b110);
    chk("b2b_wheel0", wh0, 0);

    // err_count saturation
    @(negedge clk); rxd0 = 8'h00; rxv0 = 1'b1;
    idle(300);
    rxv0 = 1'b0;
    idle(1);
    chk("err_sat", err0, 255);

    // wheel instance: timeout then full 4-byte packet
    do_reset();
    send(1, 8'h08); send(1, 8'h05);
    idle(T + 4);
    chk("w_tmo_err", err1, 1);
    send(1, 8'h08); send(1, 8'h00); send(1, 8'h00);
    chk("w_b3_pv", pv1, 0);
    send(1, 8'h0F);
    chk("w_pv", pv1, 1);
    chk("w_wheel", wh1, 4'hF);
    chk("w_x", px1, 1024);
    chk("w_err", err1, 1);
    idle(1);
    chk("w_pv_pulse", pv1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_tracker.md
# ps2_mouse_tracker

Parametrised PS/2 mouse packet decoder and cursor tracker. It consumes bytes from the PS/2 byte receiver and assembles 3-byte standard or 4-byte wheel packets, resynchronising on framing errors and inter-byte timeouts. It accumulates clamped absolute X/Y position and reports hysteretic bin indices for HEX display. It is the next-generation replacement for the fixed-mode mouse core under the DE1_SoC top.

## Interface
Parameters:
- WIDTH, 2048: X position range [0, WIDTH-1].
- HEIGHT, 2048: Y position range [0, HEIGHT-1].
- BIN, 100: position units per bin.
- HYSTERESIS, 3: extra travel required past a bin edge before the bin changes.
- BIN_W, 5: bin output width. Must hold (max(WIDTH,HEIGHT)-1)/BIN.
- WHEEL, 0: 0 selects 3-byte packets; 1 selects 4-byte IntelliMouse packets.
- TIMEOUT_CYCLES, 100000: idle clocks after which a partial packet is discarded (2 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received PS/2 byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- button_left, button_right, button_middle  out  1 each  latched button state.
- pos_x, pos_y  out  12  absolute position.
- bin_x, bin_y  out  BIN_W  hysteretic bin index.
- wheel  out  4  signed wheel delta of the last packet; always 0 when WHEEL=0.
- packet_valid  out  1  one-cycle pulse when a packet has been applied.
- err_count  out  8  saturating count of sync and timeout errors.

## Operation
- FSM states: IDLE → B1 → B2 → (WHEEL ? B3 : back to IDLE). Each state advances on rx_valid.
- IDLE: accept a byte as byte0 only if bit3=1. Otherwise drop it, stay in IDLE, and increment err_count.
- byte0 fields: [0]=L, [1]=R, [2]=M, [4]=X sign, [5]=Y sign, [6]=X overflow, [7]=Y overflow.
- dx = {Xsign, byte1} and dy = {Ysign, byte2}, both 9-bit two's complement (-256..255).
- If an axis overflow bit is set, that axis delta is treated as 0. Buttons still update.
- On the final byte, the packet is committed as follows:
  - pos_x ← clamp(pos_x + dx, 0, WIDTH-1).
  - pos_y ← clamp(pos_y − dy, 0, HEIGHT-1). PS/2 up is positive; screen Y increases downward.
  - Clamp arithmetic uses a signed 14-bit intermediate; there is no wrap-around.
  - Buttons update. wheel ← byte3[3:0] when WHEEL=1.
- Bin update, applied per axis independently, evaluated every cycle against the registered position p and bin b:
  - if p ≥ (b+1)·BIN + HYSTERESIS, or p + HYSTERESIS < b·BIN: b ← p / BIN.
  - otherwise b holds.
  - BIN is a constant, so the divide is synthesised as a constant divide.
- Timeout: in any non-IDLE state, a counter counts clocks since the last rx_valid.
  - At TIMEOUT_CYCLES the FSM returns to IDLE, the partial packet is discarded, and err_count increments.
  - The counter clears on every rx_valid.
- err_count saturates at 255.
- If a sync error and a timeout fall in the same cycle, err_count increments by only 1.

## Timing
- Reset values:
  - FSM = IDLE.
  - buttons = 0, wheel = 0, packet_valid = 0, err_count = 0.
  - pos_x = WIDTH/2, pos_y = HEIGHT/2.
  - bin_x = (WIDTH/2)/BIN, bin_y = (HEIGHT/2)/BIN.
- Latency:
  - pos_*, buttons, wheel, and packet_valid update on the clock edge that samples the final byte's rx_valid. They are visible the next cycle.
  - bin_* follow pos_* one cycle later.
- packet_valid is high for exactly one cycle per committed packet. It is never asserted for dropped or timed-out packets.
- rx_valid pulses are at least one cycle apart. Back-to-back strobes on consecutive cycles must be accepted.
- Asserting reset_n low mid-packet aborts immediately. The first byte after reset is treated as byte0.

## Test plan
Defaults unless noted (WIDTH=HEIGHT=2048, BIN=100, HYSTERESIS=3, WHEEL=0).
- Reset → pos=(1024,1024), bin=(10,10), err_count=0, packet_valid=0.
- Bytes 0x09,0x10,0x00 → button_left=1; pos_x=1040 one cycle after the third strobe; packet_valid is a single pulse; bin_x stays 10.
- Drive pos_x to 1100 → bin_x=10. Then to 1103 → bin_x=11. Back to 1099 → bin_x stays 11. Then to 1096 → bin_x=10.
- Five packets 0x18,0x00,0x00 (dx=-256) from 1024 → pos_x 768, 512, 256, 0, 0 (clamped). Then 0x48,0xFF,0x00 (X overflow) → pos_x stays 0.
- Stray byte 0x00, then packet 0x08,0x05,0x03 → err_count=1; pos=(1029,1021).
- Bytes 0x08,0x05, then 100000 idle cycles, then 0x08,0x01,0x00 → err_count=1; pos_x advances by exactly 1. Repeat with WHEEL=1, sending 0x08,0,0,0x0F → wheel=4'hF (-1).
